instruc_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. Owns the program counter and issues word-aligned fetch requests to an instruction memory with variable latency, using a valid/ready request channel and an in-order response channel. Buffers returned instructions, with their PCs, in a small FIFO and presents them to decode on a valid/ready interface. Handles PC redirects from branch and jump resolution by flushing the FIFO and discarding responses still in flight.

---
 rtl/instruc_fetch.sv | 129 ++++++++++++
 tb/tb_instruc_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruc_fetch.sv
// instruc_fetch: owns the PC, issues imem fetches, buffers {inst,pc} for decode.
// Ports: clk/reset, imem req/rsp channels, redirect in, inst out, misalign_err.
module instruc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + MAX_OUT + 1) + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW:0]   ptr_t;

  logic [31:0] fetch_pc;
  cnt_t        live_cnt;
  cnt_t        drop_cnt;
  cnt_t        fifo_cnt;
  cnt_t        pend_cnt;
  cnt_t        redir_drop;
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  ptr_t        tag_wr;
  ptr_t        tag_rd;
  logic [31:0] fifo_inst [FIFO_DEPTH];
  logic [31:0] fifo_pc   [FIFO_DEPTH];
  logic [31:0] tag_q     [FIFO_DEPTH];

  logic credit_ok;
  logic req_fire;
  logic rsp_drop;
  logic rsp_push;
  logic pop;

  assign fifo_cnt = cnt_t'(wr_ptr - rd_ptr);

  // live requests each reserve a FIFO slot; dropped ones still occupy
  // memory slots until their response returns
  assign credit_ok =
    (live_cnt + fifo_cnt < cnt_t'(FIFO_DEPTH)) &&
    (live_cnt + drop_cnt < cnt_t'(MAX_OUT));

  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_push = imem_rsp_valid && (drop_cnt == '0)
                 && (live_cnt != '0);

  assign inst_valid = !reset && !redirect_valid
                   && (wr_ptr != rd_ptr);
  assign inst       = fifo_inst[rd_ptr[AW-1:0]];
  assign inst_pc    = fifo_pc[rd_ptr[AW-1:0]];
  assign pop        = inst_valid && inst_ready;

  // a response landing in the redirect cycle retires one pending slot
  assign pend_cnt   = drop_cnt + live_cnt;
  assign redir_drop = (imem_rsp_valid && pend_cnt != '0)
                    ? pend_cnt - cnt_t'(1) : pend_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      live_cnt <= '0;
      drop_cnt <= redir_drop;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      if (req_fire) begin
        tag_q[tag_wr[AW-1:0]] <= fetch_pc;
        tag_wr   <= tag_wr + ptr_t'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - cnt_t'(1);
      end
      if (rsp_push) begin
        fifo_inst[wr_ptr[AW-1:0]] <= imem_rsp_data;
        fifo_pc[wr_ptr[AW-1:0]]   <= tag_q[tag_rd[AW-1:0]];
        wr_ptr <= wr_ptr + ptr_t'(1);
        tag_rd <= tag_rd + ptr_t'(1);
      end
      case ({req_fire, rsp_push})
        2'b10:   live_cnt <= live_cnt + cnt_t'(1);
        2'b01:   live_cnt <= live_cnt - cnt_t'(1);
        default: ;
      endcase
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid
                   && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_instruc_fetch.sv
// tb_instruc_fetch: directed tables + random run vs. a stream-level model.
// Model: delivered PCs run +4 from reset/redirect target; inst = memw(pc).
module tb_instruc_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int FD = 2;
  localparam int MO = 2;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_err;

  instruc_fetch #(
    .RESET_PC(RST_PC),
    .FIFO_DEPTH(FD),
    .MAX_OUT(MO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  function automatic logic [31:0] memw(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t memq[$];
  int    lat = 1;
  int    ncyc = 0;

  // memory model: in-order responses, each no sooner than lat cycles
  task automatic cyc();
    @(posedge clk);
    #1;
    if (memq.size() > 0 && memq[0].due <= ncyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memw(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  // stream-level reference model and protocol monitor
  logic [31:0] exp_req;
  logic [31:0] exp_inst;
  int          issued;
  int          popped;
  logic        mis_exp;
  logic        hold;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  initial begin
    hold = 1'b0;
    mis_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        memq.delete();
        exp_req  = RST_PC;
        exp_inst = RST_PC;
        issued = 0;
        popped = 0;
        mis_exp = 1'b0;
        hold = 1'b0;
      end else begin
        chk("misalign", misalign_err, mis_exp);
        if (hold && !redirect_valid) begin
          chk("hold_valid", inst_valid, 1);
          chk("hold_pc", inst_pc, hold_pc);
          chk("hold_inst", inst, hold_inst);
        end
        if (redirect_valid) begin
          chk("redir_req_valid", imem_req_valid, 0);
          chk("redir_inst_valid", inst_valid, 0);
          exp_req  = {redirect_pc[31:2], 2'b00};
          exp_inst = {redirect_pc[31:2], 2'b00};
          issued = 0;
          popped = 0;
        end else begin
          if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            exp_req += 32'd4;
            issued++;
          end
          if (inst_valid && inst_ready) begin
            chk("inst_pc", inst_pc, exp_inst);
            chk("inst", inst, memw(exp_inst));
            exp_inst += 32'd4;
            popped++;
          end
          chk("buffer_credit", 32'((issued - popped) <= FD), 1);
        end
        if (imem_rsp_valid && memq.size() > 0)
          void'(memq.pop_front());
        if (imem_req_valid && imem_req_ready)
          memq.push_back('{imem_req_addr, ncyc + lat});
        chk("max_out", 32'(memq.size() <= MO), 1);
        mis_exp = redirect_valid && (redirect_pc[1:0] != 2'b00);
        hold = inst_valid && !inst_ready;
        hold_pc = inst_pc;
        hold_inst = inst;
      end
      ncyc++;
    end
  end

  task automatic wait_req(output logic [31:0] a, output bit ok);
    ok = 0;
    a = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        ok = 1;
      end
      cyc();
      if (ok) break;
    end
    if (!ok) chk("req_timeout", 32'(ok), 1);
  endtask

  task automatic wait_pop(output logic [31:0] pc,
                          output logic [31:0] w, output bit ok);
    ok = 0;
    pc = '0;
    w = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        pc = inst_pc;
        w = inst;
        ok = 1;
      end
      cyc();
      if (ok) break;
    end
    if (!ok) chk("pop_timeout", 32'(ok), 1);
  endtask

  task automatic do_redirect(logic [31:0] pc);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] wrap_exp[3];

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    bit ok;
    bit found;
    int nreq;

    vecs[0] = '{32'h0000_0203, 32'h0000_0200, 1'b1};
    vecs[1] = '{32'h0000_0100, 32'h0000_0100, 1'b0};
    vecs[2] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b1};
    vecs[4] = '{32'h0000_0040, 32'h0000_0040, 1'b0};
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    reset = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_misalign", misalign_err, 0);
    reset = 1'b0;

    // reset release: wrap through 0xFFFF_FFFC -> 0
    for (int i = 0; i < 3; i++) begin
      wait_req(a, ok);
      chk("wrap_addr", a, wrap_exp[i]);
    end

    // decode stall: only FIFO_DEPTH requests may issue
    cyc();
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) nreq++;
      cyc();
    end
    chk("stall_nreq", nreq, FD);
    chk("stall_valid", inst_valid, 1);
    chk("stall_pc", inst_pc, 32'h0);
    chk("stall_inst", inst, memw(32'h0));
    chk("stall_req_valid", imem_req_valid, 0);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_pop(a, w, ok);
      chk("stall_order", a, 32'(4 * i));
    end

    // redirect while 0x8/0xC are in flight on slow memory
    lat = 3;
    do_redirect(32'h0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready
          && imem_req_addr == 32'hC) found = 1;
      cyc();
    end
    chk("found_c", 32'(found), 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    wait_pop(a, w, ok);
    chk("inflight_pc", a, 32'h100);
    chk("inflight_inst", w, memw(32'h100));

    // redirect in the same cycle as a response and a pop attempt
    lat = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      if (imem_rsp_valid && inst_valid) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        found = 1;
      end
    end
    chk("coincide_found", 32'(found), 1);
    @(negedge clk);
    chk("coincide_nopop", inst_valid, 0);
    cyc();
    redirect_valid = 1'b0;
    wait_pop(a, w, ok);
    chk("coincide_pc", a, 32'h300);

    // redirect table: misalign pulse and aligned restart address
    foreach (vecs[i]) begin
      do_redirect(vecs[i].rpc);
      chk("tbl_misalign", misalign_err, vecs[i].exp_mis);
      wait_req(a, ok);
      chk("tbl_addr", a, vecs[i].exp_addr);
      chk("tbl_mis_end", misalign_err, 0);
    end

    // one-cycle reset mid-stream
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mrst_inst_valid", inst_valid, 0);
    chk("mrst_misalign", misalign_err, 0);
    wait_req(a, ok);
    chk("mrst_addr", a, RST_PC);

    // random traffic against the stream model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i % 500 == 0) lat = $urandom_range(1, 4);
      reset = ($urandom_range(0, 599) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom();
    end
    cyc();
    reset = 1'b0;
    redirect_valid = 1'b0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
